// File: rtl/ref_tag_compare_pipe.sv
// Tag-compare stage of the reference-pixel cache: hit/victim selection, AXI fetch address and block counter.
// Optional miss merging of back-to-back misses on the same line is enabled by defining REF_CACHE_MISS_MERGE_EN.
module ref_tag_compare_pipe #(
  parameter int          C_N_WAY            = 4,
  parameter int          TAG_ADDR_WDTH      = 12,
  parameter int          SET_ADDR_WDTH      = 6,
  parameter int          REF_ADDR_WDTH      = 4,
  parameter int          X_BLK_WDTH         = 8,
  parameter int          Y_BLK_WDTH         = 8,
  parameter int          BU_BITS            = 3,
  parameter int          AXI_ADDR_WDTH      = 32,
  parameter int          BLOCK_NUMBER_WIDTH = 6,
  parameter int unsigned BU_OFFSET          = 64,
  parameter int unsigned BU_ROW_OFFSET      = 512,
  parameter int unsigned IU_OFFSET          = 4096,
  parameter int unsigned IU_ROW_OFFSET      = 2**20,
  parameter int unsigned FRAME_OFFSET       = 2**24
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [C_N_WAY*TAG_ADDR_WDTH-1:0]   in_way_tag,
  input  logic [C_N_WAY-1:0]                 in_way_valid,
  input  logic [TAG_ADDR_WDTH-1:0]           in_tag,
  input  logic [SET_ADDR_WDTH-1:0]           in_set_addr,
  input  logic [REF_ADDR_WDTH-1:0]           in_ref_idx,
  input  logic [X_BLK_WDTH-1:0]              in_x_blk,
  input  logic [Y_BLK_WDTH-1:0]              in_y_blk,
  input  logic                               in_block_end,
  input  logic                               in_last_block,
  input  logic                               in_luma_en,
  input  logic                               in_chma_en,
  input  logic                               flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_is_hit,
  output logic                               out_merged,
  output logic [C_N_WAY-1:0]                 out_way,
  output logic [SET_ADDR_WDTH-1:0]           out_set_addr,
  output logic [TAG_ADDR_WDTH-1:0]           out_tag,
  output logic                               out_last_block,
  output logic                               out_luma_en,
  output logic                               out_chma_en,
  output logic [BLOCK_NUMBER_WIDTH-1:0]      out_block_number,
  output logic                               ar_valid,
  input  logic                               ar_ready,
  output logic [AXI_ADDR_WDTH-1:0]           ar_addr,
  output logic                               err_multi_hit
);

  localparam int WAY_IDX_W = (C_N_WAY > 1) ? $clog2(C_N_WAY) : 1;
  localparam int AW        = AXI_ADDR_WDTH;

  logic                          full, out_done, ar_done, ar_req;
  logic                          out_fire, ar_fire, leaving, accept;
  logic [C_N_WAY-1:0]            hit_way, inv_way, rr_way, victim_way, new_way, merge_way;
  logic                          hit_any, multi_hit, any_invalid, merge_hit;
  logic [WAY_IDX_W-1:0]          rr;
  logic [BLOCK_NUMBER_WIDTH-1:0] blk_cnt;
  logic [AW-1:0]                 fetch_addr;

  assign out_valid = full && !out_done;
  assign ar_valid  = full && ar_req && !ar_done;
  assign out_fire  = out_valid && out_ready;
  assign ar_fire   = ar_valid && ar_ready;
  assign leaving   = full && (out_done || out_fire) && (!ar_req || ar_done || ar_fire);
  assign in_ready  = !full || leaving;
  assign accept    = in_valid && in_ready;

  // Lowest valid matching way wins; lowest invalid way is the preferred victim.
  always_comb begin
    hit_way     = '0;
    inv_way     = '0;
    rr_way      = '0;
    hit_any     = 1'b0;
    multi_hit   = 1'b0;
    any_invalid = 1'b0;
    for (int w = 0; w < C_N_WAY; w++) begin
      if (in_way_valid[w] && (in_way_tag[w*TAG_ADDR_WDTH +: TAG_ADDR_WDTH] == in_tag)) begin
        if (hit_any) begin
          multi_hit = 1'b1;
        end else begin
          hit_any    = 1'b1;
          hit_way[w] = 1'b1;
        end
      end
      if (!in_way_valid[w] && !any_invalid) begin
        any_invalid = 1'b1;
        inv_way[w]  = 1'b1;
      end
    end
    rr_way[rr] = 1'b1;
  end

  assign victim_way = any_invalid ? inv_way : rr_way;
  assign new_way    = hit_any ? hit_way : (merge_hit ? merge_way : victim_way);

  always_comb begin
    fetch_addr = AW'(in_ref_idx) * AW'(FRAME_OFFSET)
               + AW'(in_y_blk >> BU_BITS) * AW'(IU_ROW_OFFSET)
               + AW'(in_x_blk >> BU_BITS) * AW'(IU_OFFSET)
               + AW'(in_y_blk[BU_BITS-1:0]) * AW'(BU_ROW_OFFSET)
               + AW'(in_x_blk[BU_BITS-1:0]) * AW'(BU_OFFSET);
  end

`ifdef REF_CACHE_MISS_MERGE_EN
  logic                     rec_valid;
  logic [SET_ADDR_WDTH-1:0] rec_set;
  logic [TAG_ADDR_WDTH-1:0] rec_tag;
  logic [C_N_WAY-1:0]       rec_way;

  assign merge_hit = rec_valid && !flush && !hit_any && (rec_set == in_set_addr) && (rec_tag == in_tag);
  assign merge_way = rec_way;

  // A flush wins over a coincident miss, so the record is left invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rec_valid <= 1'b0;
      rec_set   <= '0;
      rec_tag   <= '0;
      rec_way   <= '0;
    end else if (flush) begin
      rec_valid <= 1'b0;
    end else if (accept) begin
      if (hit_any) begin
        rec_valid <= 1'b0;
      end else if (!merge_hit) begin
        rec_valid <= 1'b1;
        rec_set   <= in_set_addr;
        rec_tag   <= in_tag;
        rec_way   <= victim_way;
      end
    end
  end
`else
  assign merge_hit = 1'b0;
  assign merge_way = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr            <= '0;
      blk_cnt       <= '0;
      err_multi_hit <= 1'b0;
    end else begin
      if (accept && !hit_any && !merge_hit && !any_invalid)
        rr <= (rr == WAY_IDX_W'(C_N_WAY - 1)) ? '0 : rr + WAY_IDX_W'(1);
      if (flush)
        blk_cnt <= '0;
      else if (accept && in_block_end)
        blk_cnt <= blk_cnt + BLOCK_NUMBER_WIDTH'(1);
      if (accept && multi_hit)
        err_multi_hit <= 1'b1;
    end
  end

  // Payload only loads on acceptance, so it stays stable until both sinks have taken it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full             <= 1'b0;
      out_done         <= 1'b0;
      ar_done          <= 1'b0;
      ar_req           <= 1'b0;
      out_is_hit       <= 1'b0;
      out_merged       <= 1'b0;
      out_way          <= '0;
      out_set_addr     <= '0;
      out_tag          <= '0;
      out_last_block   <= 1'b0;
      out_luma_en      <= 1'b0;
      out_chma_en      <= 1'b0;
      out_block_number <= '0;
      ar_addr          <= '0;
    end else if (accept) begin
      full             <= 1'b1;
      out_done         <= 1'b0;
      ar_done          <= 1'b0;
      ar_req           <= !hit_any && !merge_hit;
      out_is_hit       <= hit_any;
      out_merged       <= merge_hit;
      out_way          <= new_way;
      out_set_addr     <= in_set_addr;
      out_tag          <= in_tag;
      out_last_block   <= in_last_block;
      out_luma_en      <= in_luma_en;
      out_chma_en      <= in_chma_en;
      out_block_number <= flush ? '0 : blk_cnt;
      ar_addr          <= fetch_addr;
    end else if (leaving) begin
      full     <= 1'b0;
      out_done <= 1'b0;
      ar_done  <= 1'b0;
    end else begin
      if (out_fire) out_done <= 1'b1;
      if (ar_fire)  ar_done  <= 1'b1;
    end
  end

endmodule
